// File: rtl/cache_port_arbiter_if.sv
// Bundles the two requester ports and the downstream cache port of the arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface cache_port_arbiter_if;
  logic        m0_MemRead;
  logic        m0_MemWrite;
  logic [31:0] m0_Address;
  logic [31:0] m0_Write_data;
  logic [3:0]  m0_Write_strb;
  logic        m0_Read_data_Ack;
  logic        m0_Mem_req_ack;
  logic [31:0] m0_Read_data;
  logic        m0_Read_data_valid;

  logic        m1_MemRead;
  logic [31:0] m1_Address;
  logic        m1_Read_data_Ack;
  logic        m1_Mem_req_ack;
  logic [31:0] m1_Read_data;
  logic        m1_Read_data_valid;

  logic        Mem_MemRead;
  logic        Mem_MemWrite;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_Write_data;
  logic [3:0]  Mem_Write_strb;
  logic        Mem_Read_data_Ack;
  logic        Mem_req_ack;
  logic [31:0] Mem_Read_data;
  logic        Mem_Read_data_valid;

  modport slave (
    input  m0_MemRead, m0_MemWrite, m0_Address, m0_Write_data, m0_Write_strb, m0_Read_data_Ack,
    output m0_Mem_req_ack, m0_Read_data, m0_Read_data_valid,
    input  m1_MemRead, m1_Address, m1_Read_data_Ack,
    output m1_Mem_req_ack, m1_Read_data, m1_Read_data_valid,
    output Mem_MemRead, Mem_MemWrite, Mem_Address, Mem_Write_data, Mem_Write_strb, Mem_Read_data_Ack,
    input  Mem_req_ack, Mem_Read_data, Mem_Read_data_valid
  );

  modport master (
    output m0_MemRead, m0_MemWrite, m0_Address, m0_Write_data, m0_Write_strb, m0_Read_data_Ack,
    input  m0_Mem_req_ack, m0_Read_data, m0_Read_data_valid,
    output m1_MemRead, m1_Address, m1_Read_data_Ack,
    input  m1_Mem_req_ack, m1_Read_data, m1_Read_data_valid,
    input  Mem_MemRead, Mem_MemWrite, Mem_Address, Mem_Write_data, Mem_Write_strb, Mem_Read_data_Ack,
    output Mem_req_ack, Mem_Read_data, Mem_Read_data_valid
  );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares the data-cache port between the MEM-stage sequencer (m0, fixed priority) and
// the fetch read path (m1); a starvation counter forces an m1 win after STARVE_LIMIT m0 grants.
module cache_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  reset,
  cache_port_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    G0_REQ,
    G0_RESP,
    G1_REQ,
    G1_RESP
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       write_q, write_d;
  logic       m0Req, m1Req;

  assign m0Req = bus.m0_MemRead | bus.m0_MemWrite;
  assign m1Req = bus.m1_MemRead;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      write_q  <= write_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    write_d  = write_q;

    bus.Mem_MemRead        = 1'b0;
    bus.Mem_MemWrite       = 1'b0;
    bus.Mem_Address        = 32'd0;
    bus.Mem_Write_data     = 32'd0;
    bus.Mem_Write_strb     = 4'd0;
    bus.Mem_Read_data_Ack  = 1'b0;
    bus.m0_Mem_req_ack     = 1'b0;
    bus.m0_Read_data_valid = 1'b0;
    bus.m1_Mem_req_ack     = 1'b0;
    bus.m1_Read_data_valid = 1'b0;
    bus.m0_Read_data       = bus.Mem_Read_data;
    bus.m1_Read_data       = bus.Mem_Read_data;

    unique case (state_q)
      IDLE: begin
        if (m0Req && (!m1Req || starve_q != LIMIT)) begin
          state_d  = G0_REQ;
          write_d  = bus.m0_MemWrite;
          starve_d = !m1Req ? 4'd0 : ((starve_q < LIMIT) ? starve_q + 4'd1 : LIMIT);
        end else if (m1Req) begin
          state_d  = G1_REQ;
          write_d  = 1'b0;
          starve_d = 4'd0;
        end
      end
      // Request lines are masked by the op latched at grant, so a read+write collapses to a write.
      G0_REQ: begin
        bus.Mem_MemRead    = bus.m0_MemRead & ~write_q;
        bus.Mem_MemWrite   = bus.m0_MemWrite & write_q;
        bus.Mem_Address    = bus.m0_Address;
        bus.Mem_Write_data = bus.m0_Write_data;
        bus.Mem_Write_strb = bus.m0_Write_strb;
        bus.m0_Mem_req_ack = bus.Mem_req_ack;
        if (bus.Mem_req_ack) state_d = write_q ? IDLE : G0_RESP;
      end
      G0_RESP: begin
        bus.m0_Read_data_valid = bus.Mem_Read_data_valid;
        bus.Mem_Read_data_Ack  = bus.m0_Read_data_Ack;
        if (bus.Mem_Read_data_valid && bus.m0_Read_data_Ack) state_d = IDLE;
      end
      G1_REQ: begin
        bus.Mem_MemRead    = bus.m1_MemRead;
        bus.Mem_Address    = bus.m1_Address;
        bus.m1_Mem_req_ack = bus.Mem_req_ack;
        if (bus.Mem_req_ack) state_d = G1_RESP;
      end
      G1_RESP: begin
        bus.m1_Read_data_valid = bus.Mem_Read_data_valid;
        bus.Mem_Read_data_Ack  = bus.m1_Read_data_Ack;
        if (bus.Mem_Read_data_valid && bus.m1_Read_data_Ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: grant-cycle vector table, directed multi-cycle sequences,
// and random traffic checked against a transaction-level model of the arbitration rules.
module tb_cache_port_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int RAND_CYCLES  = 3000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_port_arbiter_if bus ();

  cache_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        m0Rd, m0Wr, m1Rd, memAck, memValid;
    logic        expRd, expWr, expAck0, expAck1;
    logic [31:0] expAddr;
    logic [3:0]  expStrb;
  } vec_t;

  vec_t vecs [7];
  int   expOwner  [6] = '{0, 0, 0, 0, 1, 0};
  int   expStarve [6] = '{1, 2, 3, 4, 0, 0};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    bus.m0_MemRead = 0; bus.m0_MemWrite = 0; bus.m0_Address = 0; bus.m0_Write_data = 0;
    bus.m0_Write_strb = 0; bus.m0_Read_data_Ack = 0;
    bus.m1_MemRead = 0; bus.m1_Address = 0; bus.m1_Read_data_Ack = 0;
    bus.Mem_req_ack = 0; bus.Mem_Read_data = 0; bus.Mem_Read_data_valid = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    clearInputs();
    nextCycle();
    nextCycle();
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.m0_Address = 32'h0000_1000; bus.m0_Write_data = 32'hDEAD_BEEF; bus.m0_Write_strb = 4'hF;
    bus.m1_Address = 32'hBFC0_0000;
    bus.m0_MemRead = v.m0Rd; bus.m0_MemWrite = v.m0Wr; bus.m1_MemRead = v.m1Rd;
    bus.Mem_req_ack = v.memAck; bus.Mem_Read_data_valid = v.memValid;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " ctrl"}, 32'({bus.Mem_MemRead, bus.Mem_MemWrite, bus.Mem_Read_data_Ack,
                bus.m0_Mem_req_ack, bus.m1_Mem_req_ack, bus.m0_Read_data_valid, bus.m1_Read_data_valid}), 32'd0);
    checkOutput({tag, " addr"}, bus.Mem_Address, 32'd0);
    checkOutput({tag, " wdata"}, bus.Mem_Write_data, 32'd0);
    checkOutput({tag, " strb"}, 32'(bus.Mem_Write_strb), 32'd0);
  endtask

  // Random-traffic requester state and model of the arbitration rules.
  bit          m0Want, m0Wr, m0Both, m1Want, ownWr, inResp;
  logic [31:0] m0Addr, m0Data, m1Addr;
  logic [3:0]  m0Strb;
  int          owner, starve, grants;
  bit          dropM1;

  initial begin
    $display("[TB] start");
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 4'hF};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 4'hF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 4'hF};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 4'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 4'hF};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 4'hF};

    doReset();
    settle();
    checkIdle("reset");
    checkOutput("reset starve", 32'(dut.starve_q), 32'd0);

    // Grant-cycle table: IDLE cycle ignores stray pulses, the following cycle drives the winner.
    for (int i = 0; i < 7; i++) begin
      doReset();
      applyStimulus(vecs[i]);
      settle();
      checkIdle($sformatf("vec%0d idle", i));
      nextCycle();
      settle();
      checkOutput($sformatf("vec%0d grant", i), 32'({bus.Mem_MemRead, bus.Mem_MemWrite,
                  bus.m0_Mem_req_ack, bus.m1_Mem_req_ack}),
                  32'({vecs[i].expRd, vecs[i].expWr, vecs[i].expAck0, vecs[i].expAck1}));
      checkOutput($sformatf("vec%0d addr", i), bus.Mem_Address, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d strb", i), 32'(bus.Mem_Write_strb), 32'(vecs[i].expStrb));
      checkOutput($sformatf("vec%0d valid", i), 32'({bus.m0_Read_data_valid, bus.m1_Read_data_valid}), 32'd0);
    end

    // m0 write with the downstream ack arriving in the second request cycle.
    doReset();
    bus.m0_MemWrite = 1; bus.m0_Address = 32'h1000; bus.m0_Write_data = 32'hDEAD_BEEF; bus.m0_Write_strb = 4'hF;
    nextCycle();
    settle();
    checkOutput("wr c1", 32'({bus.Mem_MemWrite, bus.m0_Mem_req_ack}), 32'b10);
    checkOutput("wr data", bus.Mem_Write_data, 32'hDEAD_BEEF);
    nextCycle();
    bus.Mem_req_ack = 1;
    settle();
    checkOutput("wr c2", 32'({bus.Mem_MemWrite, bus.m0_Mem_req_ack}), 32'b11);
    nextCycle();
    bus.m0_MemWrite = 0; bus.Mem_req_ack = 0;
    settle();
    checkIdle("wr done");

    // m1 read: ack, then valid three cycles later.
    doReset();
    bus.m1_MemRead = 1; bus.m1_Address = 32'hBFC0_0000; bus.m0_Read_data_Ack = 1;
    nextCycle();
    bus.Mem_req_ack = 1;
    settle();
    checkOutput("m1rd req", 32'({bus.Mem_MemRead, bus.m1_Mem_req_ack, bus.m0_Mem_req_ack}), 32'b110);
    checkOutput("m1rd addr", bus.Mem_Address, 32'hBFC0_0000);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      bus.m1_MemRead = 0; bus.Mem_req_ack = 0; bus.m1_Read_data_Ack = 1;
      bus.Mem_Read_data_valid = (k == 3); bus.Mem_Read_data = 32'h2408_0001;
      settle();
      checkOutput($sformatf("m1rd valid%0d", k), 32'({bus.m0_Read_data_valid, bus.m1_Read_data_valid}),
                  (k == 3) ? 32'b01 : 32'b00);
    end
    checkOutput("m1rd data", bus.m1_Read_data, 32'h2408_0001);
    checkOutput("m1rd dack", 32'(bus.Mem_Read_data_Ack), 32'd1);
    nextCycle();
    bus.Mem_Read_data_valid = 0;
    settle();
    checkIdle("m1rd done");

    // Continuous m0 writes with m1 pending: m1 must break in after STARVE_LIMIT m0 grants.
    doReset();
    bus.m0_MemWrite = 1; bus.m0_Address = 32'h2000; bus.m0_Write_strb = 4'h3;
    bus.m1_MemRead = 1; bus.m1_Address = 32'h3000; bus.m1_Read_data_Ack = 1;
    bus.Mem_req_ack = 1; bus.Mem_Read_data_valid = 1;
    grants = 0; dropM1 = 0;
    for (int c = 0; c < 60 && grants < 6; c++) begin
      nextCycle();
      if (dropM1) bus.m1_MemRead = 0;
      settle();
      if (bus.m0_Mem_req_ack || bus.m1_Mem_req_ack) begin
        checkOutput($sformatf("starve grant%0d owner", grants),
                    32'({bus.m0_Mem_req_ack, bus.m1_Mem_req_ack}), (expOwner[grants] == 1) ? 32'b01 : 32'b10);
        checkOutput($sformatf("starve grant%0d cnt", grants), 32'(dut.starve_q), 32'(expStarve[grants]));
        if (bus.m1_Mem_req_ack) dropM1 = 1;
        grants++;
      end
    end
    checkOutput("starve grant count", 32'(grants), 32'd6);

    // Reset while m0 waits for read data; the late response must be discarded.
    doReset();
    bus.m0_MemRead = 1; bus.m0_Address = 32'h4000; bus.m0_Read_data_Ack = 1;
    nextCycle();
    bus.Mem_req_ack = 1;
    settle();
    checkOutput("rst rd ack", 32'(bus.m0_Mem_req_ack), 32'd1);
    nextCycle();
    bus.m0_MemRead = 0; bus.Mem_req_ack = 0; reset = 1;
    nextCycle();
    reset = 0; bus.Mem_Read_data_valid = 1; bus.Mem_Read_data = 32'h1234_5678;
    settle();
    checkIdle("rst late valid");
    checkOutput("rst rdata passthru", bus.m0_Read_data, 32'h1234_5678);
    nextCycle();
    bus.Mem_Read_data_valid = 0;

    // Random traffic against the transaction-level model.
    doReset();
    m0Want = 0; m1Want = 0; owner = -1; inResp = 0; starve = 0; ownWr = 0;
    m0Wr = 0; m0Both = 0; m0Addr = 0; m0Data = 0; m0Strb = 0; m1Addr = 0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      logic expRd, expWr, expAck0, expAck1, expV0, expV1, expDAck;
      logic [31:0] expAddr, expWd;
      logic [3:0]  expStrb;
      nextCycle();
      if (!m0Want && $urandom_range(0, 2) == 0) begin
        m0Want = 1; m0Wr = ($urandom_range(0, 1) == 1); m0Both = ($urandom_range(0, 7) == 0);
        m0Addr = $urandom; m0Data = $urandom; m0Strb = 4'($urandom_range(0, 15));
      end
      if (!m1Want && $urandom_range(0, 3) == 0) begin
        m1Want = 1; m1Addr = $urandom;
      end
      bus.m0_MemRead = m0Want && (!m0Wr || m0Both);
      bus.m0_MemWrite = m0Want && m0Wr;
      bus.m0_Address = m0Addr; bus.m0_Write_data = m0Data; bus.m0_Write_strb = m0Strb;
      bus.m1_MemRead = m1Want; bus.m1_Address = m1Addr;
      bus.m0_Read_data_Ack = ($urandom_range(0, 1) == 1);
      bus.m1_Read_data_Ack = ($urandom_range(0, 1) == 1);
      bus.Mem_req_ack = ($urandom_range(0, 1) == 1);
      bus.Mem_Read_data_valid = ($urandom_range(0, 1) == 1);
      bus.Mem_Read_data = $urandom;
      settle();

      expRd = 0; expWr = 0; expAck0 = 0; expAck1 = 0; expV0 = 0; expV1 = 0; expDAck = 0;
      expAddr = 0; expWd = 0; expStrb = 0;
      if (owner == 0 && !inResp) begin
        expRd = !ownWr; expWr = ownWr; expAddr = m0Addr; expWd = m0Data; expStrb = m0Strb;
        expAck0 = bus.Mem_req_ack;
      end else if (owner == 1 && !inResp) begin
        expRd = 1; expAddr = m1Addr; expAck1 = bus.Mem_req_ack;
      end else if (owner == 0) begin
        expV0 = bus.Mem_Read_data_valid; expDAck = bus.m0_Read_data_Ack;
      end else if (owner == 1) begin
        expV1 = bus.Mem_Read_data_valid; expDAck = bus.m1_Read_data_Ack;
      end
      checkOutput($sformatf("rand%0d ctrl", c),
                  32'({bus.Mem_MemRead, bus.Mem_MemWrite, bus.Mem_Read_data_Ack, bus.m0_Mem_req_ack,
                       bus.m1_Mem_req_ack, bus.m0_Read_data_valid, bus.m1_Read_data_valid}),
                  32'({expRd, expWr, expDAck, expAck0, expAck1, expV0, expV1}));
      checkOutput($sformatf("rand%0d addr", c), bus.Mem_Address, expAddr);
      checkOutput($sformatf("rand%0d wdata", c), bus.Mem_Write_data, expWd);
      checkOutput($sformatf("rand%0d strb", c), 32'(bus.Mem_Write_strb), 32'(expStrb));
      checkOutput($sformatf("rand%0d rdata", c), bus.m0_Read_data ^ bus.m1_Read_data ^ bus.Mem_Read_data,
                  bus.Mem_Read_data);

      if (owner == -1) begin
        if (m0Want && (!m1Want || starve != STARVE_LIMIT)) begin
          owner = 0; ownWr = m0Wr;
          starve = m1Want ? ((starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT) : 0;
        end else if (m1Want) begin
          owner = 1; ownWr = 0; starve = 0;
        end
      end else if (!inResp) begin
        if (bus.Mem_req_ack) begin
          if (owner == 0) m0Want = 0; else m1Want = 0;
          if (ownWr) owner = -1; else inResp = 1;
        end
      end else if (bus.Mem_Read_data_valid &&
                   ((owner == 0) ? bus.m0_Read_data_Ack : bus.m1_Read_data_Ack)) begin
        owner = -1; inResp = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
